// File: rtl/mg_cpa_pipe.sv
// Pipelined Kogge-Stone carry-propagate adder with valid/ready flow control.
// Optional signed-overflow output enabled by defining MG_CPA_OVF_EN.
module mg_cpa_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef MG_CPA_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int L = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
  } gp_t;

  // Prefix level reached by register stage s.
  function automatic int lvl(input int s);
    return (s * L) / STAGES;
  endfunction

  function automatic gp_t ks_level(input gp_t x, input int k);
    gp_t y;
    int  d;
    d = 1 << (k - 1);
    y = x;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= d) begin
        y.g[i] = x.g[i] | (x.p[i] & x.g[i-d]);
        y.p[i] = x.p[i] & x.p[i-d];
      end
    end
    return y;
  endfunction

  // ---------------- flow control ----------------
  logic [STAGES:1] r_vld;
  logic [STAGES:0] w_vld_pipe;
  logic [STAGES:1] w_rdy;

  assign w_vld_pipe = {r_vld, in_valid};

  // A stage can load if any stage from it to the output is empty, or the
  // output is being drained; closed form avoids a self-referencing chain.
  for (genvar s = 1; s <= STAGES; s++) begin : g_rdy
    assign w_rdy[s] = out_ready | ~(&r_vld[STAGES:s]);
  end

  assign in_ready  = w_rdy[1];
  assign out_valid = r_vld[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      for (int s = 1; s <= STAGES; s++)
        if (w_rdy[s]) r_vld[s] <= w_vld_pipe[s-1];
    end
  end

  // ---------------- datapath ----------------
  // Index s holds the state leaving stage s; index 0 is the pre-processed input.
  logic [WIDTH-1:0] w_sg [STAGES];
  logic [WIDTH-1:0] w_sp [STAGES];
  logic [WIDTH-1:0] w_sb [STAGES];
  logic             w_sc [STAGES];
  logic [WIDTH-1:0] w_p0;

  assign w_p0    = a ^ b;
  assign w_sp[0] = w_p0;
  assign w_sb[0] = w_p0;
  assign w_sc[0] = cin;
  assign w_sg[0] = (a & b) | {{(WIDTH-1){1'b0}}, w_p0[0] & cin};

  for (genvar s = 1; s < STAGES; s++) begin : g_stg
    localparam int LO = lvl(s - 1);
    localparam int HI = lvl(s);
    gp_t              w_nx;
    logic [WIDTH-1:0] r_g, r_p, r_b;
    logic             r_c;

    always_comb begin
      w_nx = {w_sg[s-1], w_sp[s-1]};
      for (int k = LO + 1; k <= HI; k++) w_nx = ks_level(w_nx, k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_g <= '0;
        r_p <= '0;
        r_b <= '0;
        r_c <= 1'b0;
      end else if (w_rdy[s] && w_vld_pipe[s-1]) begin
        r_g <= w_nx.g;
        r_p <= w_nx.p;
        r_b <= w_sb[s-1];
        r_c <= w_sc[s-1];
      end
    end

    assign w_sg[s] = r_g;
    assign w_sp[s] = r_p;
    assign w_sb[s] = r_b;
    assign w_sc[s] = r_c;
  end

  // Output stage: remaining prefix levels, sum XOR, and result registers.
  localparam int FLO = lvl(STAGES - 1);
  gp_t              w_fx;
  logic [WIDTH-1:0] w_G;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  always_comb begin
    w_fx = {w_sg[STAGES-1], w_sp[STAGES-1]};
    for (int k = FLO + 1; k <= L; k++) w_fx = ks_level(w_fx, k);
  end

  assign w_G   = w_fx.g;
  assign w_sum = w_sb[STAGES-1] ^ {w_G[WIDTH-2:0], w_sc[STAGES-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_rdy[STAGES] && w_vld_pipe[STAGES-1]) begin
      r_sum  <= w_sum;
      r_cout <= w_G[WIDTH-1];
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef MG_CPA_OVF_EN
  // Carry into the MSB differs from carry out of it.
  logic r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_ovf <= 1'b0;
    else if (w_rdy[STAGES] && w_vld_pipe[STAGES-1]) r_ovf <= w_G[WIDTH-1] ^ w_G[WIDTH-2];
  end
  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_mg_cpa_pipe.sv
// Scoreboard bench for mg_cpa_pipe (WIDTH=16, STAGES=2): driver pushes expected
// results on accept, an independent monitor pops and checks on each output transfer.
module tb_mg_cpa_pipe;
  localparam int W = 16;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef MG_CPA_OVF_EN
  logic         ovf;
`endif

  mg_cpa_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef MG_CPA_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W:0] ex;
    logic       ov;
    int         t;
    bit         lat;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   n_acc = 0;
  bit   rnd_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: checks every output transfer and output stability under stall.
  logic [W:0] held;
  bit         hold_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        tests++;
        if (out_valid !== 1'b1 || {cout, sum} !== held) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b 0x%0h expected v=1 0x%0h", out_valid, {cout, sum}, held);
        end
      end
      if (out_valid && out_ready) begin
        hold_v = 1'b0;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got 0x%0h with no result outstanding", {cout, sum});
        end else begin
          e = q.pop_front();
          tests++;
          if ({cout, sum} !== e.ex) begin
            fails++;
            $display("FAIL result: got 0x%0h expected 0x%0h", {cout, sum}, e.ex);
          end
`ifdef MG_CPA_OVF_EN
          tests++;
          if (ovf !== e.ov) begin
            fails++;
            $display("FAIL ovf: got %0b expected %0b", ovf, e.ov);
          end
`endif
          if (e.lat) begin
            tests++;
            if (cyc - e.t != S) begin
              fails++;
              $display("FAIL latency: got %0d expected %0d", cyc - e.t, S);
            end
          end
        end
      end else if (out_valid) begin
        held   = {cout, sum};
        hold_v = 1'b1;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Present one operand set; push its expected result on the accepting cycle.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic [W:0] ex, input bit lat);
    bit ok;
    exp_t e;
    ok = 1'b0;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.ex  = ex;
        e.ov  = (ta[W-1] ~^ tb[W-1]) & (ex[W-1] ^ ta[W-1]);
        e.t   = cyc;
        e.lat = lat;
        q.push_back(e);
        n_acc++;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  initial begin
    int base;
    logic [W-1:0] ra, rb;
    logic         rc;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef MG_CPA_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Directed vectors, no backpressure, latency checked
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1, 17'h10000, 1'b1);
    send(16'h1234, 16'h4321, 1'b1, 17'h05556, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1);
    send(16'hAAAA, 16'h5555, 1'b1, 17'h10000, 1'b1);
    send(16'h0000, 16'h0000, 1'b0, 17'h00000, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b1);
    drain();

    // Backpressure: output blocked, pipe fills after two accepts
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(W'(i), W'(3 * i), i[0], 17'(4 * i + (i & 1)), 1'b0);
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_accepts", n_acc - base, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random operands with random gaps and random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          ra = W'($urandom);
          rb = W'($urandom);
          rc = 1'($urandom);
          send(ra, rb, rc, model(ra, rb, rc), 1'b0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two results in flight
    out_ready = 1'b0;
    send(16'h0101, 16'h0202, 1'b0, 17'h00303, 1'b0);
    send(16'h0404, 16'h0505, 1'b1, 17'h0090A, 1'b0);
    #2;
    chk("mid_full", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send(16'h0F0F, 16'h00F1, 1'b0, 17'h01000, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
